// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: latency-MUL_LAT multiply, restoring divide.
// Define MULDIV_EARLY_FINISH_EN to finish divide-by-zero one cycle after start.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_MUL = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] C_DIV = CW'(WIDTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [1:0]       r_state;
  logic             r_sgn;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_early;
  logic             w_in_sgn;
  logic [WIDTH-1:0] w_in_amag;
  logic             w_in_mul;
  logic             w_mul_sgn;
  logic [WIDTH-1:0] w_mul_a;
  logic [WIDTH-1:0] w_mul_b;
  logic [W2-1:0]    w_ea;
  logic [W2-1:0]    w_eb;
  logic [W2-1:0]    w_prod;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_bmag;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_dz;

  assign w_accept = start_i & ~cancel_i &
                    ((r_state == S_IDLE) | (r_state == S_DONE));

`ifdef MULDIV_EARLY_FINISH_EN
  assign w_early = (opb_i == '0);
`else
  assign w_early = 1'b0;
`endif

  assign w_in_sgn  = ~op_i[0];
  assign w_in_amag = (w_in_sgn & opa_i[WIDTH-1]) ? -opa_i : opa_i;

  // Multiplier reads the live inputs only when the product is due at acceptance
  assign w_in_mul  = (r_state == S_MUL);
  assign w_mul_sgn = w_in_mul ? r_sgn : w_in_sgn;
  assign w_mul_a   = w_in_mul ? r_a : opa_i;
  assign w_mul_b   = w_in_mul ? r_b : opb_i;
  assign w_ea      = {{WIDTH{w_mul_sgn & w_mul_a[WIDTH-1]}}, w_mul_a};
  assign w_eb      = {{WIDTH{w_mul_sgn & w_mul_b[WIDTH-1]}}, w_mul_b};
  assign w_prod    = w_ea * w_eb;

  assign w_a_neg  = r_sgn & r_a[WIDTH-1];
  assign w_b_neg  = r_sgn & r_b[WIDTH-1];
  assign w_bmag   = w_b_neg ? -r_b : r_b;
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, w_bmag});
  assign w_rem_nx = w_ge ? (w_shift[WIDTH-1:0] - w_bmag)
                         : w_shift[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
  assign w_q_fix  = (w_a_neg ^ w_b_neg) ? -w_quo_nx : w_quo_nx;
  assign w_r_fix  = w_a_neg ? -w_rem_nx : w_rem_nx;
  assign w_dz     = (r_b == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sgn   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_sgn <= w_in_sgn;
            r_a   <= opa_i;
            r_b   <= opb_i;
            r_quo <= w_in_amag;
            r_rem <= '0;
            if (op_i[1]) begin
              if (w_early) begin
                r_state <= S_DONE;
                r_hi    <= opa_i;
                r_lo    <= {WIDTH{1'b1}};
              end else begin
                r_state <= S_DIV;
                r_cnt   <= C_DIV;
              end
            end else if (MUL_LAT == 1) begin
              r_state <= S_DONE;
              r_hi    <= w_prod[W2-1:WIDTH];
              r_lo    <= w_prod[WIDTH-1:0];
            end else begin
              r_state <= S_MUL;
              r_cnt   <= C_MUL;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          if (cancel_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt == C_ONE) begin
            r_state <= S_DONE;
            r_hi    <= w_prod[W2-1:WIDTH];
            r_lo    <= w_prod[WIDTH-1:0];
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_DIV: begin
          if (cancel_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - C_ONE;
            // Final quotient bit lands with the sign fix-up in one step
            if (r_cnt == C_ONE) begin
              r_state <= S_DONE;
              r_hi    <= w_dz ? r_a : w_r_fix;
              r_lo    <= w_dz ? {WIDTH{1'b1}} : w_q_fix;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (r_state == S_MUL) | (r_state == S_DIV);
  assign done_o = (r_state == S_DONE);
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-low reset; all other timing is synchronous to the rising edge of clk.
REQ-002 Parameter WIDTH, default 32, SHALL set the operand width; the legal range is 8..64.
REQ-003 Parameter MUL_LAT, default 2, SHALL set the multiply latency in cycles; the legal range is 1..4.
REQ-004 The ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  asynchronous reset, active low
- start_i  in  1  request a new operation
- op_i  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- cancel_i  in  1  flush the in-flight operation (exception or pipeline flush)
- opa_i  in  WIDTH  rs operand (dividend or multiplicand)
- opb_i  in  WIDTH  rt operand (divisor or multiplier)
- busy_o  out  1  an operation is in flight
- done_o  out  1  one-cycle pulse: result is valid
- hi_o  out  WIDTH  product high half, or remainder
- lo_o  out  WIDTH  product low half, or quotient

Function
REQ-005 The state machine SHALL have the states IDLE, MUL, DIV and DONE; busy_o SHALL be 1 exactly in MUL and DIV.
REQ-006 start_i SHALL be accepted only in IDLE or DONE with cancel_i=0; on acceptance, op_i, opa_i and opb_i SHALL be captured, and later changes to these inputs SHALL have no effect on the operation.
REQ-007 start_i SHALL be ignored while busy_o=1.
REQ-008 Acceptance of a multiply SHALL go to MUL; done_o SHALL pulse exactly MUL_LAT cycles after the acceptance cycle.
REQ-009 MULT SHALL form a signed 2*WIDTH product and MULTU an unsigned one; {hi_o, lo_o} SHALL equal the product.
REQ-010 Acceptance of a divide SHALL go to DIV, which SHALL perform restoring division on magnitudes, producing one quotient bit per cycle for WIDTH cycles; the sign fix-up and the done_o pulse SHALL occur WIDTH+1 cycles after acceptance.
REQ-011 For DIV, the quotient sign SHALL equal sign(opa) XOR sign(opb), and the remainder sign SHALL equal sign(opa).
REQ-012 DIV of the most negative value by -1 SHALL give lo_o equal to the most negative value and hi_o=0, with no exception.
REQ-013 Divide by zero SHALL give lo_o all ones and hi_o equal to the dividend, for both DIV and DIVU.
REQ-014 The block SHALL be in DONE for exactly one cycle with done_o=1, then go to IDLE unless a new start is accepted in that same cycle, which allows back-to-back operations.
REQ-015 hi_o and lo_o SHALL update only in the done_o cycle and SHALL hold their values until the next done_o.
REQ-016 cancel_i=1 in MUL or DIV SHALL force IDLE at the next edge; done_o SHALL NOT pulse for the cancelled operation and hi_o/lo_o SHALL stay unchanged.
REQ-017 If cancel_i and start_i are both 1 in the same cycle, cancel_i SHALL win and the start SHALL NOT be accepted.
REQ-018 cancel_i=1 in the DONE cycle SHALL NOT suppress that cycle's done_o or its result update.

Reset
REQ-019 When rst=0, the state SHALL be IDLE, busy_o and done_o SHALL be 0, and hi_o, lo_o and all internal registers SHALL be 0, immediately and regardless of clk.
REQ-020 Reset asserted mid-operation SHALL abandon the operation, and no done_o SHALL follow after reset is released.

Configuration
REQ-021 When macro MULDIV_EARLY_FINISH_EN is defined, a divide with opb=0 SHALL skip iteration and pulse done_o 1 cycle after acceptance, with the results of REQ-013.
REQ-022 When MULDIV_EARLY_FINISH_EN is undefined, every divide, including divide by zero, SHALL take WIDTH+1 cycles and give the same result values as REQ-013.

Verification (WIDTH=32, MUL_LAT=2, cycle 0 = acceptance cycle)
REQ-023 MULT with opa=0xFFFFFFFE, opb=3 -> done_o at cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-024 DIV with opa=0xFFFFFFF9 (-7), opb=2 -> done_o at cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV with opa=0x80000000, opb=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-025 DIVU with opa=5, opb=0 -> lo=0xFFFFFFFF, hi=5; done_o at cycle 1 with MULDIV_EARLY_FINISH_EN defined, at cycle 33 without it.
REQ-026 Start a DIV, then raise cancel_i together with start_i at cycle 10 -> busy_o=0 at cycle 11, no done_o within 40 cycles, hi/lo unchanged, and the start not accepted.
REQ-027 Start a MULT, then raise start_i for a DIVU during its done_o cycle -> both done_o pulses occur, at cycles 2 and 35, each with its correct result.
REQ-028 Assert rst=0 at cycle 5 of a DIV -> all outputs 0 with no clock edge; after release, no done_o and busy_o=0.
